// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: icache request/response, redirect, and decode window.
// master = the fetch queue itself; slave = the icache/decode side driving it.
interface fetch_queue_if;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic         ic_v;
  logic [127:0] ic_line;
  logic         redirect;
  logic [31:0]  redirect_eip;
  logic         de_take;
  logic [3:0]   de_len;
  logic         de_v;
  logic [127:0] de_instr;
  logic [31:0]  de_eip;

  modport master (
    output ic_req, ic_addr, de_v, de_instr, de_eip,
    input  ic_v, ic_line, redirect, redirect_eip, de_take, de_len
  );

  modport slave (
    input  ic_req, ic_addr, de_v, de_instr, de_eip,
    output ic_v, ic_line, redirect, redirect_eip, de_take, de_len
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch byte queue: line fetches into a circular byte buffer, EIP-aligned window.
// Optional FETCH_QUEUE_STATS_EN adds fq_bubble_cnt (cycles with no valid window, no redirect).
module fetch_queue #(
  parameter int unsigned DEPTH_LINES = 4,
  parameter logic [31:0] RESET_EIP   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [31:0]   fq_bubble_cnt,
`endif
  fetch_queue_if.master bus
);
  localparam int unsigned Cap   = 16 * DEPTH_LINES;
  localparam int unsigned PtrW  = $clog2(Cap);
  localparam int unsigned SlotW = $clog2(DEPTH_LINES);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [1:0] {StFill, StWait, StSquash} state_e;

  state_e          state_q;
  logic [7:0]      mem_q [Cap];
  logic [PtrW-1:0] head_q;
  logic [SlotW-1:0] tail_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     fetch_addr_q;
  logic [31:0]     de_eip_q;
  logic [3:0]      first_off_q;
  logic            ic_req_q;
  logic [31:0]     ic_addr_q;
  logic            de_v_q;

  logic            take;
  logic            fill;
  logic            space_ok;
  logic [CntW-1:0] fill_amt;
  logic [CntW-1:0] take_amt;
  logic [CntW-1:0] count_d;
  logic [127:0]    window;

  // Fill and consume fold into a single count update so neither is lost.
  always_comb begin
    take     = bus.de_take && de_v_q && (bus.de_len != 4'd0);
    fill     = (state_q == StWait) && bus.ic_v;
    space_ok = count_q <= CntW'(Cap - 16);
    fill_amt = fill ? (CntW'(16) - CntW'(first_off_q)) : '0;
    take_amt = take ? CntW'(bus.de_len) : '0;
    count_d  = count_q + fill_amt - take_amt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Cap; i++) mem_q[i] <= '0;
      head_q       <= PtrW'(RESET_EIP[3:0]);
      tail_q       <= '0;
      count_q      <= '0;
      fetch_addr_q <= {RESET_EIP[31:4], 4'h0};
      de_eip_q     <= RESET_EIP;
      first_off_q  <= RESET_EIP[3:0];
      ic_req_q     <= 1'b0;
      ic_addr_q    <= {RESET_EIP[31:4], 4'h0};
      de_v_q       <= 1'b0;
      state_q      <= StFill;
    end else begin
      ic_req_q <= 1'b0;
      if (bus.redirect) begin
        head_q       <= PtrW'(bus.redirect_eip[3:0]);
        tail_q       <= '0;
        count_q      <= '0;
        first_off_q  <= bus.redirect_eip[3:0];
        de_eip_q     <= bus.redirect_eip;
        fetch_addr_q <= {bus.redirect_eip[31:4], 4'h0};
        de_v_q       <= 1'b0;
        // A response still in flight must be discarded; one arriving now is simply dropped.
        unique case (state_q)
          StWait, StSquash: state_q <= bus.ic_v ? StFill : StSquash;
          default:          state_q <= StFill;
        endcase
      end else begin
        if (fill) begin
          for (int unsigned k = 0; k < 16; k++) begin
            mem_q[{tail_q, k[3:0]}] <= bus.ic_line[8*k +: 8];
          end
          tail_q       <= tail_q + SlotW'(1);
          fetch_addr_q <= fetch_addr_q + 32'd16;
          first_off_q  <= '0;
        end
        if (take) begin
          head_q   <= head_q + PtrW'(bus.de_len);
          de_eip_q <= de_eip_q + 32'(bus.de_len);
        end
        count_q <= count_d;
        de_v_q  <= count_d >= CntW'(16);
        unique case (state_q)
          StFill: begin
            if (space_ok) begin
              state_q   <= StWait;
              ic_req_q  <= 1'b1;
              ic_addr_q <= fetch_addr_q;
            end
          end
          StWait:   if (bus.ic_v) state_q <= StFill;
          StSquash: if (bus.ic_v) state_q <= StFill;
          default:  state_q <= StFill;
        endcase
      end
    end
  end

  always_comb begin
    window = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      window[8*k +: 8] = mem_q[head_q + PtrW'(k)];
    end
  end

  assign bus.ic_req   = ic_req_q;
  assign bus.ic_addr  = ic_addr_q;
  assign bus.de_v     = de_v_q;
  assign bus.de_instr = window;
  assign bus.de_eip   = de_eip_q;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (!de_v_q && !bus.redirect && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign fq_bubble_cnt = bubble_q;
`endif
endmodule
